// File: rtl/uart_fmt_pkg.sv
// Shared definitions for the result formatter and its decimal converter.
// Holds the ASCII constants used when building a record, the state
// encodings of both state machines, and small helpers for digit handling.
package uart_fmt_pkg;

    localparam logic [7:0] ZERO = 8'h30;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    // Record formatter sequencing.
    typedef enum logic [2:0] {
        IDLE,
        CONV_Q,
        SEND_Q,
        SEND_SEP,
        CONV_R,
        SEND_R,
        SEND_CR,
        SEND_LF
    } fmt_state_t;

    // Converter phases: hundreds extraction, then tens extraction.
    typedef enum logic [1:0] {
        C_IDLE,
        C_HUND,
        C_TENS
    } conv_state_t;

    // Digit position of the most significant non-zero digit
    // (2 = hundreds, 1 = tens, 0 = ones). A value of 0 still sends "0".
    function automatic logic [1:0] first_digit(logic [1:0] h, logic [3:0] t);
        if (h != 2'd0)
            return 2'd2;
        else if (t != 4'd0)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [7:0] to_ascii(logic [3:0] d);
        return ZERO + {4'd0, d};
    endfunction

endpackage

// File: rtl/bin2dec_seq.sv
// Sequential binary-to-decimal converter using repeated subtraction.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, val[7:0]     start pulse and the value to convert (sampled together)
//   done                one-cycle pulse once the digits below are final
//   hundreds/tens/ones  decimal digits, held until the next start
// Latency from a sampled start to done is h + t + 2 cycles: one cycle per
// subtraction plus one exit-compare cycle in each of the two phases.
module bin2dec_seq
    import uart_fmt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] val,
    output logic       done,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    conv_state_t state;
    conv_state_t next_state;
    logic [7:0]  work;

    always_ff @(posedge clk) begin
        if (rst)
            state <= C_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            C_IDLE: if (start)         next_state = C_HUND;
            C_HUND: if (work < 8'd100) next_state = C_TENS;
            C_TENS: if (work < 8'd10)  next_state = C_IDLE;
            default:                   next_state = C_IDLE;
        endcase
    end

    // Datapath: whatever is left in work after the tens phase is the ones digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= 8'd0;
            hundreds <= 2'd0;
            tens     <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (start) begin
                        work     <= val;
                        hundreds <= 2'd0;
                        tens     <= 4'd0;
                    end
                end
                C_HUND: begin
                    if (work >= 8'd100) begin
                        work     <= work - 8'd100;
                        hundreds <= hundreds + 2'd1;
                    end
                end
                C_TENS: begin
                    if (work >= 8'd10) begin
                        work <= work - 8'd10;
                        tens <= tens + 4'd1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ones = work[3:0];

endmodule

// File: rtl/result_formatter.sv
// Formats a divider result as an ASCII record "<quotient><SEP><remainder>"
// optionally followed by CR LF, and streams it byte by byte over a
// valid/ready handshake to a UART transmitter.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load, res, rem      capture pulse with quotient and remainder
//   busy                high while a record is in progress
//   tx_data, tx_valid   byte offered to the transmitter
//   tx_ready            transmitter accepts the offered byte
//   done                one-cycle pulse after the last byte transfers
module result_formatter
    import uart_fmt_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR  = 8'h72,
    parameter bit         EMIT_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] res,
    input  logic [7:0] rem,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done
);

    fmt_state_t state;
    fmt_state_t next_state;
    logic [7:0] rem_q;
    logic [1:0] digit_idx;
    logic [7:0] digit_char;

    logic       conv_start;
    logic [7:0] conv_val;
    logic       conv_done;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    // One converter serves both fields. The quotient is fed straight from
    // res on the capture edge; the remainder comes from rem_q once the
    // separator has gone out.
    bin2dec_seq u_conv (
        .clk      (clk),
        .rst      (rst),
        .start    (conv_start),
        .val      (conv_val),
        .done     (conv_done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    always_comb begin
        case (digit_idx)
            2'd2:    digit_char = to_ascii({2'd0, hundreds});
            2'd1:    digit_char = to_ascii(tens);
            default: digit_char = to_ascii(ones);
        endcase
    end

    always_comb begin
        next_state = state;
        conv_start = 1'b0;
        conv_val   = rem_q;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            IDLE: begin
                if (load) begin
                    next_state = CONV_Q;
                    conv_start = 1'b1;
                    conv_val   = res;
                end
            end
            CONV_Q: if (conv_done) next_state = SEND_Q;
            SEND_Q: begin
                tx_valid = 1'b1;
                tx_data  = digit_char;
                if (tx_ready && digit_idx == 2'd0) next_state = SEND_SEP;
            end
            SEND_SEP: begin
                tx_valid = 1'b1;
                tx_data  = SEP_CHAR;
                if (tx_ready) begin
                    next_state = CONV_R;
                    conv_start = 1'b1;
                end
            end
            CONV_R: if (conv_done) next_state = SEND_R;
            SEND_R: begin
                tx_valid = 1'b1;
                tx_data  = digit_char;
                if (tx_ready && digit_idx == 2'd0)
                    next_state = EMIT_CRLF ? SEND_CR : IDLE;
            end
            SEND_CR: begin
                tx_valid = 1'b1;
                tx_data  = CR;
                if (tx_ready) next_state = SEND_LF;
            end
            SEND_LF: begin
                tx_valid = 1'b1;
                tx_data  = LF;
                if (tx_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // digit_idx starts at the most significant non-zero digit when a
    // conversion finishes and counts down once per transferred digit.
    // Every path back to IDLE from a busy state is a final-byte transfer,
    // which is what raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem_q     <= 8'd0;
            digit_idx <= 2'd0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state != IDLE) && (next_state == IDLE);
            if (state == IDLE && load)
                rem_q <= rem;
            if ((state == CONV_Q || state == CONV_R) && conv_done)
                digit_idx <= first_digit(hundreds, tens);
            else if ((state == SEND_Q || state == SEND_R) && tx_ready && digit_idx != 2'd0)
                digit_idx <= digit_idx - 2'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_result_formatter.sv
// Self-checking bench for result_formatter: directed vector table, converter
// latency checks, reset corner cases and randomized records compared
// against a string-formatting reference model.
module tb_result_formatter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] res;
    logic [7:0] rem;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;

    int total_count = 0;
    int pass_count  = 0;

    result_formatter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .res      (res),
        .rem      (rem),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [7:0] r;
        logic [7:0] m;
        int         mode;
        bit         inject;
        string      text;
        string      name;
    } vec_t;

    vec_t tbl[5];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_count++;
        if (actual == expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference model: the record is just the decimal text of both values
    // around the separator, followed by CR LF.
    function automatic string model_text(logic [7:0] r, logic [7:0] m);
        return $sformatf("%0d%c%0d", r, 8'h72, m);
    endfunction

    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m);
        @(negedge clk);
        res  = r;
        rem  = m;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready toggles, 2: random ready.
    // inject: fire a second load with res=9 while the record is busy.
    task automatic run_record(input logic [7:0] r, input logic [7:0] m, input int mode,
                              input bit inject, input string text, input string name);
        byte unsigned exp_q[$];
        byte unsigned got_q[$];
        int   cycles;
        int   done_cnt;
        bit   pend;
        bit   stall_ok;
        bit   rdy;
        logic [7:0] pend_data;
        for (int i = 0; i < text.len(); i++) exp_q.push_back(text[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        applyStimulus(r, m);
        checkOutput({name, "_busy_after_load"}, int'(busy), 1);
        cycles   = 0;
        done_cnt = 0;
        pend     = 1'b0;
        stall_ok = 1'b1;
        while (got_q.size() < exp_q.size() && cycles < 400) begin
            if (pend && (!tx_valid || tx_data != pend_data)) stall_ok = 1'b0;
            if (done) done_cnt++;
            if (inject && cycles == 2) begin
                load = 1'b1; res = 8'd9; rem = 8'd9;
            end else begin
                load = 1'b0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 2) == 1;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            if (tx_valid && rdy) begin
                got_q.push_back(tx_data);
                pend = 1'b0;
            end else if (tx_valid) begin
                pend      = 1'b1;
                pend_data = tx_data;
            end
            @(negedge clk);
            cycles++;
        end
        load = 1'b0;
        checkOutput({name, "_length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", name, i),
                        (i < got_q.size()) ? int'(got_q[i]) : -1, int'(exp_q[i]));
        checkOutput({name, "_stall_stable"}, int'(stall_ok), 1);
        checkOutput({name, "_no_early_done"}, done_cnt, 0);
        checkOutput({name, "_done_pulse"}, int'(done), 1);
        checkOutput({name, "_busy_at_done"}, int'(busy), 0);
        tx_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_done_one_cycle"}, int'(done), 0);
    endtask

    // Converter latency for the quotient: done should appear exactly
    // hundreds + tens + 2 edges after the capture edge.
    task automatic conv_latency(input logic [7:0] v);
        int lat;
        int exp_lat;
        int waited;
        exp_lat = int'(v) / 100 + (int'(v) % 100) / 10 + 2;
        tx_ready = 1'b1;
        applyStimulus(v, 8'd0);
        lat = 0;
        while (!dut.u_conv.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput($sformatf("conv_latency_%0d", v), lat, exp_lat);
        waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("conv_record_end_%0d", v), int'(busy), 0);
        tx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;
        logic [7:0] rr;
        logic [7:0] mm;

        tbl[0] = '{8'd25,  8'd3,   0, 1'b0, "25r3",    "rec_25_3"};
        tbl[1] = '{8'd0,   8'd0,   0, 1'b0, "0r0",     "rec_0_0"};
        tbl[2] = '{8'd255, 8'd255, 1, 1'b0, "255r255", "rec_255_toggle"};
        tbl[3] = '{8'd100, 8'd7,   0, 1'b0, "100r7",   "rec_100_7"};
        tbl[4] = '{8'd25,  8'd3,   0, 1'b1, "25r3",    "rec_load_while_busy"};

        rst = 1'b1; load = 1'b0; res = 8'd0; rem = 8'd0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy",     int'(busy),     0);
        checkOutput("reset_tx_valid", int'(tx_valid), 0);
        checkOutput("reset_done",     int'(done),     0);
        checkOutput("reset_tx_data",  int'(tx_data),  0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_record(tbl[i].r, tbl[i].m, tbl[i].mode, tbl[i].inject, tbl[i].text, tbl[i].name);

        conv_latency(8'd100);
        conv_latency(8'd0);
        conv_latency(8'd255);
        conv_latency(8'd199);
        conv_latency(8'd99);

        // Reset while a byte is stalled on the handshake.
        tx_ready = 1'b0;
        applyStimulus(8'd200, 8'd200);
        waited = 0;
        while (!tx_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midbyte_valid_before_reset", int'(tx_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midbyte_reset_tx_valid", int'(tx_valid), 0);
        checkOutput("midbyte_reset_busy",     int'(busy),     0);
        checkOutput("midbyte_reset_tx_data",  int'(tx_data),  0);
        checkOutput("midbyte_reset_conv_h",   int'(dut.u_conv.hundreds), 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset and load in the same cycle: reset wins.
        rst = 1'b1; load = 1'b1; res = 8'd5; rem = 8'd5;
        @(negedge clk);
        checkOutput("rst_priority_busy", int'(busy), 0);
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        checkOutput("rst_priority_idle_after", int'(busy), 0);

        run_record(8'd12, 8'd1, 0, 1'b0, "12r1", "rec_after_reset");

        for (int k = 0; k < 16; k++) begin
            rr = 8'($urandom_range(0, 255));
            mm = 8'($urandom_range(0, 255));
            run_record(rr, mm, 2, 1'b0, model_text(rr, mm), $sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
